// File: rtl/reg_file_mp.sv
// Multi-read-port, single-write-port, byte-enabled register file with a
// sequential clear engine (one word per cycle) so the storage can map to RAM.

module reg_file_mp_rd_port #(
    parameter int ADDR_WIDTH     = 5,
    parameter int BYTES_PER_WORD = 4,
    parameter int ZERO_REG0      = 1,
    parameter int BYPASS         = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ready,
    input  logic                          rd_en,
    input  logic [ADDR_WIDTH-1:0]         rd_addr,
    input  logic [8*BYTES_PER_WORD-1:0]   stored,
    input  logic                          wr_go,
    input  logic [ADDR_WIDTH-1:0]         wr_addr,
    input  logic [BYTES_PER_WORD-1:0]     byte_en,
    input  logic [8*BYTES_PER_WORD-1:0]   wr_data,
    output logic [8*BYTES_PER_WORD-1:0]   rd_data
);
    logic [8*BYTES_PER_WORD-1:0] merged;

    // Forward enabled write lanes; word 0 overrides everything when hardwired.
    always_comb begin
        merged = stored;
        if (BYPASS != 0 && wr_go && wr_addr == rd_addr) begin
            for (int i = 0; i < BYTES_PER_WORD; i++)
                if (byte_en[i])
                    merged[8*i +: 8] = wr_data[8*i +: 8];
        end
        if (ZERO_REG0 != 0 && rd_addr == '0)
            merged = '0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            rd_data <= '0;
        else if (ready && rd_en)
            rd_data <= merged;
    end
endmodule

module reg_file_mp #(
    parameter int ADDR_WIDTH     = 5,
    parameter int BYTES_PER_WORD = 4,
    parameter int NUM_RD_PORTS   = 2,
    parameter int ZERO_REG0      = 1,
    parameter int BYPASS         = 1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    output logic                                    busy,
    input  logic [NUM_RD_PORTS-1:0]                 rd_en,
    input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0]      rd_addr,
    output logic [NUM_RD_PORTS*8*BYTES_PER_WORD-1:0] rd_data,
    input  logic                                    wr_en,
    input  logic [ADDR_WIDTH-1:0]                   wr_addr,
    input  logic [BYTES_PER_WORD-1:0]               byte_en,
    input  logic [8*BYTES_PER_WORD-1:0]             wr_data
);
    localparam int W     = 8*BYTES_PER_WORD;
    localparam int DEPTH = 2**ADDR_WIDTH;

    typedef enum logic {CLEAR, READY} state_t;

    state_t                  state, state_nx;
    logic [ADDR_WIDTH-1:0]   clr_cnt, clr_cnt_nx;
    logic                    mem_we, wr_go;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [BYTES_PER_WORD-1:0] mem_be;
    logic [W-1:0]            mem_wdata;
    logic [W-1:0]            mem [DEPTH];
    logic [NUM_RD_PORTS-1:0][W-1:0] stored;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nx;
            clr_cnt <= clr_cnt_nx;
        end
    end

    // The clear engine borrows the single write port while busy.
    always_comb begin
        state_nx   = state;
        clr_cnt_nx = clr_cnt;
        mem_we     = 1'b0;
        wr_go      = 1'b0;
        mem_addr   = wr_addr;
        mem_be     = byte_en;
        mem_wdata  = wr_data;
        case (state)
            CLEAR: begin
                mem_we     = 1'b1;
                mem_addr   = clr_cnt;
                mem_be     = '1;
                mem_wdata  = '0;
                clr_cnt_nx = clr_cnt + 1'b1;
                if (clr_cnt == '1)
                    state_nx = READY;
            end
            READY: begin
                wr_go  = wr_en;
                mem_we = wr_en && !(ZERO_REG0 != 0 && wr_addr == '0);
            end
            default: state_nx = CLEAR;
        endcase
    end

    assign busy = (state == CLEAR);

    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            for (int i = 0; i < BYTES_PER_WORD; i++)
                if (mem_be[i])
                    mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
    end

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
        assign stored[p] = mem[rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH]];

        reg_file_mp_rd_port #(
            .ADDR_WIDTH     (ADDR_WIDTH),
            .BYTES_PER_WORD (BYTES_PER_WORD),
            .ZERO_REG0      (ZERO_REG0),
            .BYPASS         (BYPASS)
        ) u_port (
            .clk     (clk),
            .rst     (rst),
            .ready   (state == READY),
            .rd_en   (rd_en[p]),
            .rd_addr (rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH]),
            .stored  (stored[p]),
            .wr_go   (wr_go),
            .wr_addr (wr_addr),
            .byte_en (byte_en),
            .wr_data (wr_data),
            .rd_data (rd_data[p*W +: W])
        );
    end
endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: directed vector table, mid-clear reset and hold
// sequences, then random traffic checked against an array-based model.

module tb_reg_file_mp;
    localparam int AW = 4, BPW = 4, NP = 3, W = 32, DEPTH = 16;

    logic              clk = 0;
    logic              rst;
    logic              busy;
    logic [NP-1:0]     rd_en;
    logic [NP*AW-1:0]  rd_addr;
    logic [NP*W-1:0]   rd_data;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [BPW-1:0]    byte_en;
    logic [W-1:0]      wr_data;

    reg_file_mp #(.ADDR_WIDTH(AW), .BYTES_PER_WORD(BPW), .NUM_RD_PORTS(NP),
                  .ZERO_REG0(1), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .busy(busy), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr), .byte_en(byte_en),
        .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    logic [W-1:0] mm [DEPTH];
    logic [W-1:0] er [NP];
    int clr_left = 0;
    bit known = 0;
    int n_cmp = 0, n_bad = 0;

    typedef struct {
        logic we; logic [3:0] wa; logic [3:0] be; logic [31:0] wd;
        logic [2:0] re; logic [3:0] ra0, ra1, ra2;
        logic [31:0] e0, e1, e2;
    } vec_t;
    vec_t tbl [9];

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] merge(input logic [W-1:0] old, input logic [W-1:0] nw,
                                           input logic [BPW-1:0] be);
        logic [W-1:0] m = '0;
        for (int i = 0; i < BPW; i++)
            if (be[i]) m |= 32'hFF << (8*i);
        return (old & ~m) | (nw & m);
    endfunction

    task automatic model_step();
        logic [AW-1:0] a;
        logic [W-1:0] v;
        if (rst) begin
            known = 1;
            clr_left = DEPTH;
            for (int p = 0; p < NP; p++) er[p] = '0;
        end else if (clr_left > 0) begin
            clr_left--;
            if (clr_left == 0)
                for (int i = 0; i < DEPTH; i++) mm[i] = '0;
        end else begin
            for (int p = 0; p < NP; p++) begin
                if (rd_en[p]) begin
                    a = rd_addr[p*AW +: AW];
                    v = mm[a];
                    if (wr_en && wr_addr == a) v = merge(v, wr_data, byte_en);
                    if (a == 0) v = '0;
                    er[p] = v;
                end
            end
            if (wr_en && wr_addr != 0)
                mm[wr_addr] = merge(mm[wr_addr], wr_data, byte_en);
        end
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge clk);
        #1;
        if (known) begin
            check({tag, " busy"}, {31'b0, busy}, {31'b0, clr_left > 0});
            for (int p = 0; p < NP; p++)
                check($sformatf("%s rd%0d", tag, p), rd_data[p*W +: W], er[p]);
        end
    endtask

    task automatic idle();
        rst = 0; wr_en = 0; rd_en = '0;
    endtask

    task automatic rand_ops(input bit rd_all);
        wr_en   = $urandom_range(0, 1);
        wr_addr = AW'($urandom);
        byte_en = BPW'($urandom);
        wr_data = $urandom;
        rd_en   = rd_all ? '1 : NP'($urandom);
        rd_addr = NP*AW'($urandom);
    endtask

    task automatic read_all_words(input string tag);
        idle();
        for (int a = 0; a < DEPTH; a++) begin
            rd_en = '1;
            rd_addr = {AW'(a), AW'(a), AW'(a)};
            cycle(tag);
            for (int p = 0; p < NP; p++)
                check({tag, " zero"}, rd_data[p*W +: W], 32'h0);
        end
    endtask

    initial begin
        rd_addr = '0; wr_addr = '0; byte_en = '0; wr_data = '0;
        idle();

        // Clear after a 2-cycle reset; random ops during busy must vanish.
        rst = 1;
        cycle("rst");
        cycle("rst");
        rst = 0;
        for (int i = 0; i < DEPTH; i++) begin
            rand_ops(1);
            wr_en = 1;
            cycle("clear");
            check("clear rd0", rd_data[W-1:0], 32'h0);
        end
        check("clear done busy", {31'b0, busy}, 32'h0);
        read_all_words("post_clear");

        tbl[0] = '{1, 5, 4'hF, 32'hDEADBEEF, 3'b000, 0, 0, 0, 32'h0, 32'h0, 32'h0};
        tbl[1] = '{0, 0, 4'h0, 32'h0,        3'b001, 5, 0, 0, 32'hDEADBEEF, 32'h0, 32'h0};
        tbl[2] = '{1, 5, 4'h5, 32'h11223344, 3'b000, 0, 0, 0, 32'hDEADBEEF, 32'h0, 32'h0};
        tbl[3] = '{0, 0, 4'h0, 32'h0,        3'b111, 5, 5, 5, 32'hDE22BE44, 32'hDE22BE44, 32'hDE22BE44};
        tbl[4] = '{1, 7, 4'h3, 32'hCAFEF00D, 3'b111, 7, 7, 7, 32'h0000F00D, 32'h0000F00D, 32'h0000F00D};
        tbl[5] = '{1, 0, 4'hF, 32'hFFFFFFFF, 3'b111, 0, 0, 0, 32'h0, 32'h0, 32'h0};
        tbl[6] = '{0, 0, 4'h0, 32'h0,        3'b111, 0, 0, 0, 32'h0, 32'h0, 32'h0};
        tbl[7] = '{0, 0, 4'h0, 32'h0,        3'b111, 7, 5, 0, 32'h0000F00D, 32'hDE22BE44, 32'h0};
        tbl[8] = '{1, 7, 4'h8, 32'h12345678, 3'b010, 0, 7, 0, 32'h0000F00D, 32'h1200F00D, 32'h0};
        for (int i = 0; i < 9; i++) begin
            wr_en = tbl[i].we; wr_addr = tbl[i].wa; byte_en = tbl[i].be; wr_data = tbl[i].wd;
            rd_en = tbl[i].re; rd_addr = {tbl[i].ra2, tbl[i].ra1, tbl[i].ra0};
            cycle($sformatf("vec%0d", i));
            check($sformatf("tbl%0d p0", i), rd_data[0*W +: W], tbl[i].e0);
            check($sformatf("tbl%0d p1", i), rd_data[1*W +: W], tbl[i].e1);
            check($sformatf("tbl%0d p2", i), rd_data[2*W +: W], tbl[i].e2);
        end

        // Reset re-asserted on clear edge 8 restarts the full clear.
        idle();
        rst = 1;
        cycle("mid_rst");
        rst = 0;
        for (int i = 0; i < 7; i++) begin
            rand_ops(0); wr_en = 1;
            cycle("mid_clear");
        end
        rst = 1;
        cycle("mid_rst2");
        rst = 0;
        for (int i = 0; i < DEPTH; i++) begin
            rand_ops(0); wr_en = 1;
            check("restart busy pre", {31'b0, busy}, 32'h1);
            cycle("restart");
        end
        check("restart busy end", {31'b0, busy}, 32'h0);
        read_all_words("post_restart");

        // rd_en=0 holds the registered value while the word keeps changing.
        idle();
        wr_en = 1; wr_addr = 3; byte_en = 4'hF; wr_data = 32'hA5A50F0F;
        cycle("hold_wr");
        idle();
        rd_en = 3'b100; rd_addr = {4'd3, 4'd0, 4'd0};
        cycle("hold_rd");
        for (int i = 0; i < 5; i++) begin
            idle();
            wr_en = 1; wr_addr = 3; byte_en = 4'hF; wr_data = $urandom;
            cycle("hold");
            check("hold p2", rd_data[2*W +: W], 32'hA5A50F0F);
        end

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            rand_ops(0);
            rst = ($urandom_range(0, 149) == 0);
            cycle("rand");
        end
        idle();
        for (int i = 0; i < 2*DEPTH && clr_left > 0; i++)
            cycle("drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
